// File: rtl/twiddle_mult_stage_pkg.sv
// Shared FFT definitions for the twiddle multiplier stage: default widths,
// product width, saturation limits and the complex sample type.
package twiddle_mult_stage_pkg;

   localparam int SIZE_DEF = 8;
   localparam int TW_DEF   = 8;
   localparam int PROD_W   = SIZE_DEF + TW_DEF + 1;
   localparam int SAT_MAX  = (1 << (SIZE_DEF - 1)) - 1;
   localparam int SAT_MIN  = -(1 << (SIZE_DEF - 1));

   typedef struct packed {
      logic [SIZE_DEF-1:0] re;
      logic [SIZE_DEF-1:0] im;
   } cplx_t;

   function automatic int sat_hi(input int size);
      return (1 << (size - 1)) - 1;
   endfunction

   function automatic int sat_lo(input int size);
      return -(1 << (size - 1));
   endfunction

endpackage

// File: rtl/twiddle_mult_stage_scale_sat.sv
// Combinational rescale of one product component: optional round (TWIDDLE_ROUND_EN),
// arithmetic shift by TW-1, saturate to SIZE bits and flag the clip.
module twiddle_mult_stage_scale_sat
   import twiddle_mult_stage_pkg::*;
#(
   parameter int SIZE = SIZE_DEF,
   parameter int TW   = TW_DEF
) (
   input  logic signed [SIZE+TW:0] sum,
   output logic [SIZE-1:0]         q,
   output logic                    clip
);
   localparam int PW = SIZE + TW + 1;
   localparam logic signed [PW-1:0] HI = PW'(sat_hi(SIZE));
   localparam logic signed [PW-1:0] LO = PW'(sat_lo(SIZE));

   logic signed [PW-1:0] biased;
   logic signed [PW-1:0] shifted;

`ifdef TWIDDLE_ROUND_EN
   // Full-width add: the largest product magnitude leaves headroom for the half-LSB.
   localparam logic signed [PW-1:0] HALF = PW'(2 ** (TW - 2));
   assign biased = sum + HALF;
`else
   assign biased = sum;
`endif

   assign shifted = biased >>> (TW - 1);

   always_comb begin
      clip = 1'b0;
      q    = shifted[SIZE-1:0];
      if (shifted > HI) begin
         clip = 1'b1;
         q    = HI[SIZE-1:0];
      end else if (shifted < LO) begin
         clip = 1'b1;
         q    = LO[SIZE-1:0];
      end
   end

endmodule

// File: rtl/twiddle_mult_stage.sv
// Three-stage complex twiddle multiplier: passes A, emits scaled/saturated B*W.
// The whole pipe freezes when the output beat is held. Rounding via TWIDDLE_ROUND_EN.
module twiddle_mult_stage
   import twiddle_mult_stage_pkg::*;
#(
   parameter int SIZE = SIZE_DEF,
   parameter int TW   = TW_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [SIZE-1:0] a_re,
   input  logic [SIZE-1:0] a_im,
   input  logic [SIZE-1:0] b_re,
   input  logic [SIZE-1:0] b_im,
   input  logic [TW-1:0]   w_re,
   input  logic [TW-1:0]   w_im,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [SIZE-1:0] oa_re,
   output logic [SIZE-1:0] oa_im,
   output logic [SIZE-1:0] p_re,
   output logic [SIZE-1:0] p_im,
   output logic            sat
);
   localparam int MW = SIZE + TW;
   localparam int PW = SIZE + TW + 1;

   logic            adv;
   logic            v1, v2;
   logic [SIZE-1:0] a1_re, a1_im, a2_re, a2_im;
   logic [SIZE-1:0] b1_re, b1_im;
   logic [TW-1:0]   w1_re, w1_im;
   logic signed [MW-1:0] bx_re, bx_im, wx_re, wx_im;
   logic signed [MW-1:0] m_rr, m_ii, m_ri, m_ir;
   logic signed [PW-1:0] sum_re, sum_im;
   logic [SIZE-1:0] q_re, q_im;
   logic            clip_re, clip_im;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // Sign-extend to the product width so the low MW bits hold the exact signed product.
   assign bx_re = $signed({{TW{b1_re[SIZE-1]}}, b1_re});
   assign bx_im = $signed({{TW{b1_im[SIZE-1]}}, b1_im});
   assign wx_re = $signed({{SIZE{w1_re[TW-1]}}, w1_re});
   assign wx_im = $signed({{SIZE{w1_im[TW-1]}}, w1_im});

   assign sum_re = $signed({m_rr[MW-1], m_rr}) - $signed({m_ii[MW-1], m_ii});
   assign sum_im = $signed({m_ri[MW-1], m_ri}) + $signed({m_ir[MW-1], m_ir});

   twiddle_mult_stage_scale_sat #(.SIZE(SIZE), .TW(TW)) u_scale_re (
      .sum  (sum_re),
      .q    (q_re),
      .clip (clip_re)
   );

   twiddle_mult_stage_scale_sat #(.SIZE(SIZE), .TW(TW)) u_scale_im (
      .sum  (sum_im),
      .q    (q_im),
      .clip (clip_im)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         out_valid <= 1'b0;
         a1_re     <= '0;
         a1_im     <= '0;
         a2_re     <= '0;
         a2_im     <= '0;
         b1_re     <= '0;
         b1_im     <= '0;
         w1_re     <= '0;
         w1_im     <= '0;
         m_rr      <= '0;
         m_ii      <= '0;
         m_ri      <= '0;
         m_ir      <= '0;
         oa_re     <= '0;
         oa_im     <= '0;
         p_re      <= '0;
         p_im      <= '0;
         sat       <= 1'b0;
      end else if (adv) begin
         v1        <= in_valid;
         a1_re     <= a_re;
         a1_im     <= a_im;
         b1_re     <= b_re;
         b1_im     <= b_im;
         w1_re     <= w_re;
         w1_im     <= w_im;
         v2        <= v1;
         a2_re     <= a1_re;
         a2_im     <= a1_im;
         m_rr      <= bx_re * wx_re;
         m_ii      <= bx_im * wx_im;
         m_ri      <= bx_re * wx_im;
         m_ir      <= bx_im * wx_re;
         out_valid <= v2;
         oa_re     <= a2_re;
         oa_im     <= a2_im;
         p_re      <= q_re;
         p_im      <= q_im;
         sat       <= clip_re | clip_im;
      end
   end

endmodule

// File: doc/twiddle_mult_stage.md
# twiddle_mult_stage

Pipelined complex twiddle multiplier that feeds the radix-2 butterfly adders. It accepts an operand pair (A, B) and twiddle W. It emits A unchanged plus the product B·W, rounded and saturated back to SIZE bits, so the downstream `signed_adder` instances can form A ± B·W directly. A valid/ready handshake on both sides lets the stage stall under downstream backpressure.

## Interface
- `SIZE`, 8: data width; two's-complement integer, per real/imag component.
- `TW`, 8: twiddle width; two's-complement Q1.(TW-1) format.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: input beat present.
- `in_ready`  out  1: stage can accept a beat this cycle.
- `a_re`, `a_im`  in  SIZE each: A operand, passed through.
- `b_re`, `b_im`  in  SIZE each: B operand, multiplied.
- `w_re`, `w_im`  in  TW each: twiddle factor.
- `out_valid`  out  1: output beat present.
- `out_ready`  in  1: downstream accepts the beat.
- `oa_re`, `oa_im`  out  SIZE each: delayed A.
- `p_re`, `p_im`  out  SIZE each: B·W, scaled.
- `sat`  out  1: either component of the current output beat clipped.

## Operation
- A transfer occurs on any cycle where valid and ready are both high, on each side independently.
- Global advance enable: `adv = !out_valid | out_ready`.
  - All pipeline registers, including the valid bits, load only when `adv` is high.
  - `in_ready = adv` (combinational).
- Stage 1 registers the inputs and the valid bit. A bubble (`in_valid=0`) loads `valid=0`.
- Stage 2 forms four full products, each SIZE+TW bits signed: `b_re*w_re`, `b_im*w_im`, `b_re*w_im`, `b_im*w_re`.
- Stage 3 forms the sums, each SIZE+TW+1 bits signed:
  - `re = b_re*w_re - b_im*w_im`
  - `im = b_re*w_im + b_im*w_re`
- Scaling:
  - Arithmetic shift right by TW-1, with or without rounding per Configuration.
  - Then saturate to [-2^(SIZE-1), 2^(SIZE-1)-1].
  - `sat` = OR of the clip events on re and im. It is registered with the output and meaningful only while `out_valid` is high.
- The A operand travels through matching delay registers, so `oa_*` always pairs with the `p_*` of the same input beat.
- No state machine. Control is the 3-deep valid shift chain gated by `adv`.

## Timing
- Latency: 3 cycles from input acceptance to `out_valid` when there is no stall.
- Throughput: 1 beat/cycle while `out_ready` stays high.
- Stall behaviour:
  - While `out_valid=1` and `out_ready=0`, every register holds and `in_ready=0`.
  - The outputs stay stable until accepted.
- Bubbles are not squeezed out during a stall. The pipeline freezes as a unit.
- Reset: all valid bits clear to 0. `out_valid=0`, `sat=0`, `oa_*=0`, `p_*=0` on the cycle after `rst` is sampled high.
  - `in_ready=1` immediately after reset, because `out_valid=0`.
  - `rst` has priority over `adv`.
- Reset mid-stream discards every in-flight beat with no partial output.
- `w = -1.0` (-2^(TW-1)) combined with `b` at the negative extreme can overflow. Saturation handles this and asserts `sat`.

## Configuration
- `TWIDDLE_ROUND_EN` defined:
  - Add 2^(TW-2) before the shift (round half up).
  - The add is done at SIZE+TW+1 width, so it cannot wrap before saturation.
- Not defined: plain truncation (floor) by the arithmetic shift; the rounding adder is absent.
- Latency and handshake are identical in both builds.

## Structure
- The shared FFT package holds:
  - the `SIZE`/`TW` defaults
  - the product width constant SIZE+TW+1
  - the saturation limits
  - a `cplx_t` packed struct holding the re/im pair
- Sub-module `scale_sat`: one instance per component. It is combinational: round (per macro), shift, saturate, and report clip. The pipeline registers stay in the parent.

## Test plan
- Basic scaling: b=(64,0), w=(127,0), a=(5,-3).
  - Without the macro: p=(63,0).
  - With `TWIDDLE_ROUND_EN`: p=(64,0).
  - Both builds: oa=(5,-3), sat=0, out_valid exactly 3 cycles after acceptance.
- Multiply by j: b=(10,20), w=(0,127).
  - Without the macro: p=(-20,9).
  - With the macro: p=(-20,10).
- Saturation: b=(-128,-128), w=(-128,-128) → p=(0,127), sat=1.
- Backpressure: stream 8 beats with `in_valid` held high and `out_ready` toggling 1,0,0,1,….
  - All 8 outputs arrive in order with correct oa/p pairing.
  - No beat is dropped or duplicated.
  - Outputs are held stable while `out_ready=0`.
  - `in_ready` mirrors `adv`.
- Reset mid-operation: assert `rst` for 1 cycle with 3 beats in flight.
  - Next cycle: out_valid=0, sat=0, in_ready=1.
  - None of the flushed beats appear at the output afterward.
